// File: rtl/ahb_vga_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_vga_master
// Description : AHB-Lite single-master bridge. Commands are queued in a FIFO
//               and issued as pipelined single-word NONSEQ transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_vga_master #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic [31:0] rsp_rdata,
    output logic        HSEL,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    output logic        HREADY,
    input  logic        HREADYOUT,
    input  logic [31:0] HRDATA,
    output logic        busy
);

    localparam int                 c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int                 c_cnt_w   = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [1:0]         c_idle    = 2'b00;
    localparam logic [1:0]         c_nonseq  = 2'b10;

    // Command storage; addresses are kept word-aligned (bits [31:2] only)
    logic               r_fifo_write [FIFO_DEPTH];
    logic [29:0]        r_fifo_addr  [FIFO_DEPTH];
    logic [31:0]        r_fifo_wdata [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic               r_ap_valid;
    logic               r_ap_write;
    logic [29:0]        r_ap_addr;
    logic [31:0]        r_ap_wdata;

    logic               r_dp_valid;
    logic               r_dp_write;
    logic [29:0]        r_dp_addr;
    logic [31:0]        r_dp_wdata;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_done;
    logic               w_unused;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_depth);
    assign w_push   = cmd_valid && !w_full;
    assign w_pop    = !w_empty && (!r_ap_valid || HREADYOUT);
    assign w_done   = r_dp_valid && HREADYOUT;
    assign w_unused = &{1'b0, cmd_addr[1:0], r_dp_addr};

    always_ff @(posedge HCLK) begin
        if (w_push) begin
            r_fifo_write[r_wr_ptr] <= cmd_write;
            r_fifo_addr[r_wr_ptr]  <= cmd_addr[31:2];
            r_fifo_wdata[r_wr_ptr] <= cmd_wdata;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Address phase: refills from the FIFO head whenever the slot frees up
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_ap_valid <= 1'b0;
            r_ap_write <= 1'b0;
            r_ap_addr  <= '0;
            r_ap_wdata <= '0;
        end else if (w_pop) begin
            r_ap_valid <= 1'b1;
            r_ap_write <= r_fifo_write[r_rd_ptr];
            r_ap_addr  <= r_fifo_addr[r_rd_ptr];
            r_ap_wdata <= r_fifo_wdata[r_rd_ptr];
        end else if (r_ap_valid && HREADYOUT) begin
            r_ap_valid <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_dp_addr  <= '0;
            r_dp_wdata <= '0;
        end else if (HREADYOUT) begin
            r_dp_valid <= r_ap_valid;
            r_dp_write <= r_ap_valid && r_ap_write;
            r_dp_addr  <= r_ap_addr;
            r_dp_wdata <= r_ap_wdata;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= w_done;
            if (w_done) begin
                rsp_write <= r_dp_write;
                rsp_rdata <= r_dp_write ? 32'h0 : HRDATA;
            end
        end
    end

    assign cmd_ready = !w_full;
    assign HSEL      = r_ap_valid;
    assign HTRANS    = r_ap_valid ? c_nonseq : c_idle;
    assign HADDR     = r_ap_valid ? {r_ap_addr, 2'b00} : 32'h0;
    assign HWRITE    = r_ap_valid && r_ap_write;
    assign HSIZE     = 3'b010;
    assign HWDATA    = (r_dp_valid && r_dp_write) ? r_dp_wdata : 32'h0;
    assign HREADY    = HREADYOUT;
    assign busy      = !w_empty || r_ap_valid || r_dp_valid;

endmodule
`default_nettype wire

// File: tb/tb_ahb_vga_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_vga_master
// Description : Directed self-checking bench for ahb_vga_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_vga_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        busy;

    int tests  = 0;
    int failed = 0;

    ahb_vga_master #(.FIFO_DEPTH(4)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .busy      (busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        HRESET    = 1'b1;
        HREADYOUT = 1'b1;
        HRDATA    = 32'h0;
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        HRESET = 1'b0;

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_hsel",      32'(HSEL),      32'd0);
        chk("rst_htrans",    32'(HTRANS),    32'd0);
        chk("rst_haddr",     HADDR,          32'h0);
        chk("rst_hwrite",    32'(HWRITE),    32'd0);
        chk("rst_hwdata",    HWDATA,         32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata,      32'h0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("hsize",         32'(HSIZE),     32'd2);

        // Single write, zero wait states
        set_cmd(1'b1, 1'b1, 32'h5000_0004, 32'h0000_00A5);
        step();                                   // N: push
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        chk("w_busy_n",     32'(busy),   32'd1);
        chk("w_htrans_n",   32'(HTRANS), 32'd0);
        step();                                   // N+1: address phase
        chk("w_htrans_n1",  32'(HTRANS), 32'd2);
        chk("w_hsel_n1",    32'(HSEL),   32'd1);
        chk("w_haddr_n1",   HADDR,       32'h5000_0004);
        chk("w_hwrite_n1",  32'(HWRITE), 32'd1);
        step();                                   // N+2: data phase
        chk("w_htrans_n2",  32'(HTRANS),    32'd0);
        chk("w_hwdata_n2",  HWDATA,         32'h0000_00A5);
        chk("w_rspv_n2",    32'(rsp_valid), 32'd0);
        step();                                   // N+3: response
        chk("w_rspv_n3",    32'(rsp_valid), 32'd1);
        chk("w_rspw_n3",    32'(rsp_write), 32'd1);
        chk("w_rspd_n3",    rsp_rdata,      32'h0);
        chk("w_busy_n3",    32'(busy),      32'd0);
        chk("w_hwdata_n3",  HWDATA,         32'h0);
        step();
        chk("w_rspv_n4",    32'(rsp_valid), 32'd0);

        // Single read, two wait states during the address phase
        HRDATA = 32'h1234_5678;
        set_cmd(1'b1, 1'b0, 32'h5000_0000, 32'hFFFF_FFFF);
        step();                                   // N
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        step();                                   // N+1
        chk("r_htrans_n1",  32'(HTRANS), 32'd2);
        chk("r_hwrite_n1",  32'(HWRITE), 32'd0);
        HREADYOUT = 1'b0;
        chk("r_hready_lo",  32'(HREADY), 32'd0);
        step();                                   // N+2 wait
        chk("r_haddr_w1",   HADDR,          32'h5000_0000);
        chk("r_htrans_w1",  32'(HTRANS),    32'd2);
        step();                                   // N+3 wait
        chk("r_haddr_w2",   HADDR,          32'h5000_0000);
        chk("r_rspv_w2",    32'(rsp_valid), 32'd0);
        HREADYOUT = 1'b1;
        step();                                   // N+4 data phase
        chk("r_htrans_n4",  32'(HTRANS),    32'd0);
        chk("r_rspv_n4",    32'(rsp_valid), 32'd0);
        chk("r_hwdata_n4",  HWDATA,         32'h0);
        step();                                   // N+5 response
        chk("r_rspv_n5",    32'(rsp_valid), 32'd1);
        chk("r_rspw_n5",    32'(rsp_write), 32'd0);
        chk("r_rspd_n5",    rsp_rdata,      32'h1234_5678);
        step();
        chk("r_rspv_n6",    32'(rsp_valid), 32'd0);

        // Unaligned address bits are dropped
        HRDATA = 32'hCAFE_0001;
        set_cmd(1'b1, 1'b0, 32'h5000_0007, 32'h0);
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("ua_haddr",     HADDR, 32'h5000_0004);
        step();
        step();
        chk("ua_rspd",      rsp_rdata, 32'hCAFE_0001);
        step();

        // Fill against a stalled slave, then drain back-to-back
        HREADYOUT = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_cmd(1'b1, 1'b1, 32'h5000_0100 + 32'(i * 4), 32'hD0 + 32'(i));
            step();
            chk($sformatf("f_ready_%0d", i), 32'(cmd_ready), (i < 4) ? 32'd1 : 32'd0);
        end
        set_cmd(1'b1, 1'b1, 32'h5000_0114, 32'hD5);
        step();
        chk("f_ready_blk",  32'(cmd_ready), 32'd0);
        chk("f_haddr_blk",  HADDR,          32'h5000_0100);
        chk("f_htrans_blk", 32'(HTRANS),    32'd2);
        HREADYOUT = 1'b1;
        step();                                   // pop frees a slot; push still blocked
        chk("f_ready_e1",   32'(cmd_ready), 32'd1);
        chk("f_haddr_e1",   HADDR,          32'h5000_0104);
        chk("f_hwdata_e1",  HWDATA,         32'hD0);
        step();                                   // sixth command accepted here
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        chk("f_haddr_e2",   HADDR,          32'h5000_0108);
        chk("f_hwdata_e2",  HWDATA,         32'hD1);
        chk("f_rspv_e2",    32'(rsp_valid), 32'd1);
        for (int k = 3; k < 6; k++) begin
            step();
            chk($sformatf("f_haddr_%0d", k),  HADDR,          32'h5000_0100 + 32'(k * 4));
            chk($sformatf("f_hwdata_%0d", k), HWDATA,         32'hD0 + 32'(k - 1));
            chk($sformatf("f_rspv_%0d", k),   32'(rsp_valid), 32'd1);
        end
        step();
        chk("f_htrans_e6",  32'(HTRANS),    32'd0);
        chk("f_hwdata_e6",  HWDATA,         32'hD5);
        chk("f_rspv_e6",    32'(rsp_valid), 32'd1);
        step();
        chk("f_rspv_e7",    32'(rsp_valid), 32'd1);
        chk("f_busy_e7",    32'(busy),      32'd0);
        step();
        chk("f_rspv_e8",    32'(rsp_valid), 32'd0);

        // Reset during the data phase of a write
        set_cmd(1'b1, 1'b1, 32'h5000_0040, 32'h0000_BEEF);
        step();
        set_cmd(1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        chk("x_hwdata_dp",  HWDATA, 32'h0000_BEEF);
        HRESET = 1'b1;
        step();
        HRESET = 1'b0;
        chk("x_htrans",     32'(HTRANS),    32'd0);
        chk("x_hsel",       32'(HSEL),      32'd0);
        chk("x_hwdata",     HWDATA,         32'h0);
        chk("x_busy",       32'(busy),      32'd0);
        chk("x_rspv0",      32'(rsp_valid), 32'd0);
        step();
        chk("x_rspv1",      32'(rsp_valid), 32'd0);
        step();
        chk("x_rspv2",      32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_vga_master.md
AHB_VGA_MASTER -- requirements
Module: ahb_vga_master

Interface
REQ-001 FIFO_DEPTH, 4, command FIFO entries; power of two, range 2..16.
REQ-002 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 HRESET  input  1  synchronous, active-high reset, sampled on rising HCLK.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  FIFO can accept a command.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  32  byte address.
REQ-008 cmd_wdata  input  32  write data.
REQ-009 rsp_valid  output  1  one-cycle completion pulse.
REQ-010 rsp_write  output  1  direction of the completed transfer.
REQ-011 rsp_rdata  output  32  read data; 0 for writes.
REQ-012 HSEL  output  1  slave select.
REQ-013 HADDR  output  32  AHB address.
REQ-014 HTRANS  output  2  2'b00 IDLE, 2'b10 NONSEQ; other codes never driven.
REQ-015 HWRITE  output  1  transfer direction.
REQ-016 HSIZE  output  3  constant 3'b010, word.
REQ-017 HWDATA  output  32  write data, data phase.
REQ-018 HREADY  output  1  combinational copy of HREADYOUT, single-slave bus.
REQ-019 HREADYOUT  input  1  slave ready / wait-state.
REQ-020 HRDATA  input  32  slave read data.
REQ-021 busy  output  1  FIFO non-empty, or an address or data phase active.

Function
REQ-022 Command FIFO: push on cmd_valid && cmd_ready; cmd_ready = !full, so a full FIFO rejects a push even in a pop cycle.
REQ-023 Two pipeline stages: address-phase register (AP) and data-phase register (DP), each with valid, write, addr and wdata.
REQ-024 AP loads the FIFO head when the FIFO is non-empty and (AP empty or HREADYOUT=1); otherwise AP holds, or clears if it advances with the FIFO empty.
REQ-025 AP valid: HSEL=1, HTRANS=NONSEQ, HADDR={addr[31:2],2'b00}, HWRITE from entry; AP empty: HSEL=0, HTRANS=IDLE, HWRITE=0, HADDR=0.
REQ-026 AP outputs held stable while HREADYOUT=0.
REQ-027 With AP valid and HREADYOUT=1, AP moves to DP; DP empties when HREADYOUT=1 and nothing advances.
REQ-028 HWDATA = DP wdata while DP holds a write, else 0; held stable through wait states.
REQ-029 DP completes on HREADYOUT=1; next cycle rsp_valid=1 for exactly one cycle, rsp_write=DP write, rsp_rdata=HRDATA captured at completion (reads) or 0 (writes).
REQ-030 Latency, zero wait states: push in cycle N -> NONSEQ in N+1 -> data phase N+2 -> rsp_valid in N+3.
REQ-031 Throughput: one transfer completed per cycle with back-to-back commands and HREADYOUT=1.
REQ-032 Each wait cycle (HREADYOUT=0) delays rsp_valid by exactly one cycle; ordering is strict FIFO order.
REQ-033 cmd_addr[1:0] ignored; no error response generated.
REQ-034 FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width $clog2(FIFO_DEPTH)+1.

Reset
REQ-035 HRESET=1 clears FIFO, AP, DP next edge: cmd_ready=1, HSEL=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_rdata=0, busy=0.
REQ-036 Reset mid-transfer abandons in-flight transfers; no rsp_valid for them afterwards.
REQ-037 HRESET has priority over simultaneous push/pop/completion.

Verification
REQ-038 Write 0x5000_0004 data 0x0000_00A5, HREADYOUT=1 -> NONSEQ at N+1, HWDATA=0xA5 at N+2, rsp_valid/rsp_write=1 at N+3.
REQ-039 Read 0x5000_0000, HRDATA=0x1234_5678, HREADYOUT low 2 cycles -> HADDR held, rsp_valid at N+5, rsp_rdata=0x1234_5678.
REQ-040 Five pushes with cmd_valid held, slave stalled -> cmd_ready=0 once full, fifth accepted only after first pop.
REQ-041 Four back-to-back writes, HREADYOUT=1 -> four consecutive rsp_valid cycles, addresses in order.
REQ-042 HRESET during data phase of a write -> bus IDLE next cycle, no rsp_valid, busy=0.
REQ-043 cmd_addr=0x5000_0007 -> HADDR=0x5000_0004.
